iterative_alu: RTL

Parametrised successor to the datapath's single-cycle ALU. Executes add, subtract, compare and logic operations in one cycle, and unsigned multiply and divide iteratively over WIDTH cycles. Uses a start/busy/done handshake so the multicycle controller can stall on long operations. Produces the CR16-style status bits (carry, low, flag, zero, negative) consumed by the status register.

---
 rtl/alu_definitions.sv | 40 ++++
 rtl/multiply_divide_unit.sv | 92 +++++++++
 rtl/iterative_alu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_definitions.sv
`default_nettype none
// ============================================================================
// Module      : alu_definitions (package)
// Description : Shared definitions for the iterative ALU and the datapath
//               status register: operation codes, status-bit positions,
//               handshake FSM state type and an operation classifier.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_definitions;

    // Operation codes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    // Bit positions of the flags inside the CR16-style status register
    localparam int STATUS_CARRY    = 0;
    localparam int STATUS_LOW      = 2;
    localparam int STATUS_FLAG     = 5;
    localparam int STATUS_ZERO     = 6;
    localparam int STATUS_NEGATIVE = 7;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_ITERATE = 1'b1
    } alu_state_e;

    // True for the operations that run through the multiply/divide unit
    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiply_divide_unit.sv
`default_nettype none
// ============================================================================
// Module      : multiply_divide_unit
// Description : Iterative unsigned shift-add multiplier and restoring divider.
//               One step per clock, WIDTH steps per operation.
// Ports       : clk_i        - rising-edge clock
//               rst_ni       - asynchronous active-low reset
//               start_i      - load operands and begin a new operation
//               is_div_i     - 1 = divide, 0 = multiply (sampled with start_i)
//               a_i, b_i     - operands (sampled with start_i)
//               last_o       - completion strobe: the final step runs this cycle
//               acc_next_o   - accumulator value after this cycle's step
//                              ({high, low} product or {remainder, quotient})
// Revision    : 1.0 - initial release
// ============================================================================
module multiply_divide_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_next_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               active_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   operand_q;   // multiplicand or divisor
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shifted;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_new;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half
        // the partial product; add then shift right with the carry.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_q[0] ? operand_q : {WIDTH{1'b0}})};

        // Divide: shift remainder:quotient left by one, trial-subtract the
        // divisor and keep the difference only when it does not go negative.
        // The shifted remainder needs WIDTH+1 bits because it may reach 2*b-1.
        rem_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge      = (rem_shifted >= {1'b0, operand_q});
        // When rem_ge holds the difference is below b, so WIDTH bits suffice.
        rem_new     = rem_ge ? (rem_shifted[WIDTH-1:0] - operand_q)
                             : rem_shifted[WIDTH-1:0];

        if (is_div_q) begin
            acc_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign last_o     = active_q && (count_q == '0);
    assign acc_next_o = acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q  <= 1'b0;
            is_div_q  <= 1'b0;
            operand_q <= '0;
            count_q   <= '0;
            acc_q     <= '0;
        end else if (start_i) begin
            active_q  <= 1'b1;
            is_div_q  <= is_div_i;
            operand_q <= is_div_i ? b_i : a_i;
            acc_q     <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
            count_q   <= CNT_W'(WIDTH - 1);
        end else if (active_q) begin
            acc_q <= acc_d;
            if (count_q == '0) begin
                active_q <= 1'b0;
            end else begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : iterative_alu
// Description : ALU with single-cycle add/sub/compare/logic and WIDTH-cycle
//               unsigned multiply/divide behind a start/busy/done handshake.
//               Produces CR16-style status bits.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               start_i, operation_i   - request and op code (sampled when idle)
//               a_i, b_i               - operands
//               busy_o                 - iterative operation in progress
//               done_o                 - one-cycle pulse, outputs just updated
//               result_o, result_high_o- primary result / high half or remainder
//               carry_o, low_o, flag_o, zero_o, negative_o - status bits
//               divide_by_zero_o       - last DIV had b = 0
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_alu
    import alu_definitions::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_high_o,
    output logic             carry_o,
    output logic             low_o,
    output logic             flag_o,
    output logic             zero_o,
    output logic             negative_o,
    output logic             divide_by_zero_o
);

    alu_state_e       state_q;
    logic             busy_q;
    logic             done_q;
    logic             is_div_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_high_q;
    logic             carry_q;
    logic             low_q;
    logic             flag_q;
    logic             zero_q;
    logic             negative_q;
    logic             dbz_q;

    // Single-cycle next values, used when a non-iterative op is accepted
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_high_d;
    logic             carry_d;
    logic             low_d;
    logic             flag_d;
    logic             zero_d;
    logic             negative_d;
    logic             dbz_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             div_by_zero_req;
    logic             iter_accept;

    logic               mdu_last;
    logic [2*WIDTH-1:0] mdu_acc;
    logic [WIDTH-1:0]   mdu_lo;
    logic [WIDTH-1:0]   mdu_hi;

    assign mdu_lo = mdu_acc[WIDTH-1:0];
    assign mdu_hi = mdu_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        sum_ext         = {1'b0, a_i} + {1'b0, b_i};
        diff_ext        = {1'b0, a_i} - {1'b0, b_i};
        div_by_zero_req = (operation_i == OP_DIV) && (b_i == '0);
        // Divide by zero completes immediately, so it never enters ITERATE
        iter_accept     = start_i && (state_q == ST_IDLE)
                       && is_iterative(operation_i) && !div_by_zero_req;

        result_d      = result_q;
        result_high_d = '0;
        carry_d       = 1'b0;
        low_d         = 1'b0;
        flag_d        = 1'b0;
        zero_d        = 1'b0;
        negative_d    = 1'b0;
        dbz_d         = 1'b0;

        case (operation_i)
            OP_ADD: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                flag_d   = (a_i[WIDTH-1] == b_i[WIDTH-1])
                        && (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
                zero_d   = (sum_ext[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                result_d = diff_ext[WIDTH-1:0];
                carry_d  = diff_ext[WIDTH];   // borrow out
                flag_d   = (a_i[WIDTH-1] != b_i[WIDTH-1])
                        && (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
                zero_d   = (diff_ext[WIDTH-1:0] == '0);
            end
            OP_CMP: begin
                // Compare leaves both result registers untouched
                result_high_d = result_high_q;
                zero_d        = (a_i == b_i);
                low_d         = (a_i < b_i);
                negative_d    = ($signed(a_i) < $signed(b_i));
            end
            OP_AND: begin
                result_d = a_i & b_i;
                zero_d   = ((a_i & b_i) == '0);
            end
            OP_OR: begin
                result_d = a_i | b_i;
                zero_d   = ((a_i | b_i) == '0);
            end
            OP_XOR: begin
                result_d = a_i ^ b_i;
                zero_d   = ((a_i ^ b_i) == '0);
            end
            OP_DIV: begin
                // Only the b = 0 case is resolved here
                result_d      = '1;
                result_high_d = a_i;
                dbz_d         = 1'b1;
            end
            default: begin
                // MUL is always iterative; nothing to produce here
            end
        endcase
    end

    multiply_divide_unit #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (iter_accept),
        .is_div_i   (operation_i == OP_DIV),
        .a_i        (a_i),
        .b_i        (b_i),
        .last_o     (mdu_last),
        .acc_next_o (mdu_acc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            is_div_q      <= 1'b0;
            result_q      <= '0;
            result_high_q <= '0;
            carry_q       <= 1'b0;
            low_q         <= 1'b0;
            flag_q        <= 1'b0;
            zero_q        <= 1'b0;
            negative_q    <= 1'b0;
            dbz_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // done is only ever high while IDLE, so a start held across a
                // done pulse is accepted here as a back-to-back request.
                ST_IDLE: begin
                    if (iter_accept) begin
                        state_q  <= ST_ITERATE;
                        busy_q   <= 1'b1;
                        is_div_q <= (operation_i == OP_DIV);
                    end else if (start_i) begin
                        result_q      <= result_d;
                        result_high_q <= result_high_d;
                        carry_q       <= carry_d;
                        low_q         <= low_d;
                        flag_q        <= flag_d;
                        zero_q        <= zero_d;
                        negative_q    <= negative_d;
                        dbz_q         <= dbz_d;
                        done_q        <= 1'b1;
                    end
                end
                ST_ITERATE: begin
                    if (mdu_last) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        result_q      <= mdu_lo;
                        result_high_q <= mdu_hi;
                        carry_q       <= !is_div_q && (mdu_hi != '0);
                        low_q         <= 1'b0;
                        flag_q        <= 1'b0;
                        zero_q        <= is_div_q ? (mdu_lo == '0) : (mdu_acc == '0);
                        negative_q    <= 1'b0;
                        dbz_q         <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign result_o         = result_q;
    assign result_high_o    = result_high_q;
    assign carry_o          = carry_q;
    assign low_o            = low_q;
    assign flag_o           = flag_q;
    assign zero_o           = zero_q;
    assign negative_o       = negative_q;
    assign divide_by_zero_o = dbz_q;

endmodule
`default_nettype wire
